cxapbasyncbridge_cdc_launch_gry_ptr: RTL and testbench
======================================================

// Module: cxapbasyncbridge_cdc_launch_gry_ptr
// PURPOSE
//  Multi-channel gray-coded CDC launch block for the async bridge pointer paths.
//  Mode 0: per-channel binary pointer counters, incremented by inc[], gray-encoded, launched from flops.
//  Mode 1: loads externally supplied gray values on enable.
//  Both modes: synthesisable per-channel gray-distance checker with sticky error flags.
//  Sits in the source clock domain; out_async feeds the destination-domain synchroniser directly.
// PARAMETERS
//  WIDTH   4  bits per channel pointer (>=2); binary counter wraps modulo 2**WIDTH
//  NUM_CH  1  number of independent channels (>=1)
//  MODE    0  0 = internal counter + bin->gray; 1 = external gray pass-through (in_cdc)
// PORTS
//  clk        in   1             source-domain clock
//  resetn     in   1             asynchronous active-low reset
//  enable     in   1             global launch enable; when low all state holds
//  inc        in   NUM_CH        per-channel pointer increment request (MODE 0 only)
//  in_cdc     in   NUM_CH*WIDTH  per-channel gray value to launch (MODE 1 only)
//  err_clr    in   1             synchronous clear of all gray_err flags
//  out_async  out  NUM_CH*WIDTH  launched gray values, driven directly by flops
//  bin_ptr    out  NUM_CH*WIDTH  per-channel binary pointer, for local-domain use only
//  gray_err   out  NUM_CH        sticky flag: launched value changed by more than one bit
// BEHAVIOUR
//  Reset and clocking
//  - Reset is resetn, asynchronous, active-low; clock is clk.
//  - On reset, every out_async, bin_ptr and gray_err bit is 0.
//  - Channel c occupies bits [c*WIDTH +: WIDTH] of every bussed port.
//  - CDC rule: out_async is a pure flop output. No combinational logic follows the launch flop.
//  MODE 0
//  - Per channel, on a clk edge with enable=1 and inc[c]=1:
//      bin_next = bin_ptr + 1 (mod 2**WIDTH)
//      out_async <= bin_next ^ (bin_next >> 1)
//      bin_ptr <= bin_next
//    Both registers update on the same edge.
//  - Latency: an inc sampled at edge N is visible on out_async and bin_ptr after edge N.
//  - At most one increment per channel per clock.
//  - inc with enable=0 is dropped. No queuing.
//  - Wrap: bin 2**WIDTH-1 -> 0, so out_async goes 10..0 -> 00..0 (a single-bit change).
//  - in_cdc is ignored.
//  MODE 1
//  - Per channel, on a clk edge with enable=1: out_async <= in_cdc.
//  - bin_ptr is the combinational gray->binary conversion of out_async.
//  - inc is ignored.
//  Checker (both modes)
//  - On a loading edge, gray_err[c] sets if popcount(new value ^ current out_async[c]) > 1.
//  - The flag sets on the same edge as the load. The bad value is still launched.
//  - gray_err holds until err_clr=1 is sampled, which clears all flags.
//  - err_clr and a new error on the same edge: the error wins, so the flag stays 1.
//  - Channels are fully independent.
//  - Reset asserted mid-operation clears all state immediately, with no partial update.
// TESTING
//  1. Reset, WIDTH=4, MODE 0 -> out_async=0, bin_ptr=0, gray_err=0. Hold inc=0 for 10 clk -> no change.
//  2. MODE 0, enable=1, inc=1 for 16 clk -> out_async sequence 1,3,2,6,...,8,0.
//     Each step has a 1-bit distance. bin_ptr returns to 0. gray_err stays 0.
//  3. MODE 0, NUM_CH=2, inc=2'b10, enable toggling each clk for 8 clk -> ch1 advances 4, ch0 stays 0.
//  4. MODE 1, in_cdc 0 -> 1 -> 3 -> 0 -> gray_err=1 after the 3->0 edge. Value 0 is launched. bin_ptr=0.
//  5. gray_err=1, then err_clr=1 together with a 2-bit jump -> gray_err stays 1.
//     Next err_clr with a legal step -> gray_err=0.
//  6. MODE 0, bin_ptr=5, assert resetn=0 mid-cycle -> outputs 0 before the next clk edge.
//     After release, the first inc -> out_async=1.

Source files
------------

// File: rtl/cxapbasyncbridge_cdc_launch_gry_ptr_if.sv
// Launch-side bus for the gray pointer CDC block: controls and data in, launched pointers out.
interface cxapbasyncbridge_cdc_launch_gry_ptr_if #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 1
);
   logic                      enable;
   logic [NUM_CH-1:0]         inc;
   logic [NUM_CH*WIDTH-1:0]   in_cdc;
   logic                      err_clr;
   logic [NUM_CH*WIDTH-1:0]   out_async;
   logic [NUM_CH*WIDTH-1:0]   bin_ptr;
   logic [NUM_CH-1:0]         gray_err;

   modport master (
      output enable, inc, in_cdc, err_clr,
      input  out_async, bin_ptr, gray_err
   );

   modport slave (
      input  enable, inc, in_cdc, err_clr,
      output out_async, bin_ptr, gray_err
   );
endinterface

// File: rtl/cxapbasyncbridge_cdc_launch_gry_ptr.sv
// Multi-channel gray-coded pointer launch for the async bridge; one channel slice per lane,
// each with a sticky checker that flags any launched step of more than one bit.
module cxapbasyncbridge_cdc_launch_gry_ptr_ch #(
   parameter int WIDTH = 4,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] in_cdc_i,
   input  logic             err_clr_i,
   output logic [WIDTH-1:0] out_async_o,
   output logic [WIDTH-1:0] bin_ptr_o,
   output logic             gray_err_o
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] gray_q, gray_d, nxt_gray, diff;
   logic             err_q, err_d, ld, dist_gt1;

   generate
      if (MODE == 0) begin : g_cnt
         logic [WIDTH-1:0] bin_q, bin_d, bin_inc;
         logic             unused_in;

         assign unused_in = ^in_cdc_i;
         assign bin_inc   = bin_q + ONE;
         assign nxt_gray  = bin_inc ^ (bin_inc >> 1);
         assign ld        = enable_i & inc_i;
         assign bin_d     = ld ? bin_inc : bin_q;
         assign bin_ptr_o = bin_q;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) bin_q <= '0;
            else         bin_q <= bin_d;
         end
      end else begin : g_ext
         logic unused_inc;

         assign unused_inc = inc_i;
         assign nxt_gray   = in_cdc_i;
         assign ld         = enable_i;

         // Local-domain binary view; never fed back across the crossing.
         always_comb begin
            bin_ptr_o = '0;
            for (int i = 0; i < WIDTH; i++) bin_ptr_o[i] = ^(gray_q >> i);
         end
      end
   endgenerate

   // More than one bit set <=> clearing the lowest set bit leaves something behind.
   assign diff     = nxt_gray ^ gray_q;
   assign dist_gt1 = |(diff & (diff - ONE));
   assign gray_d   = ld ? nxt_gray : gray_q;
   assign err_d    = (ld & dist_gt1) | (err_q & ~err_clr_i);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gray_q <= '0;
         err_q  <= 1'b0;
      end else begin
         gray_q <= gray_d;
         err_q  <= err_d;
      end
   end

   assign out_async_o = gray_q;
   assign gray_err_o  = err_q;
endmodule

module cxapbasyncbridge_cdc_launch_gry_ptr #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 1,
   parameter int MODE   = 0
) (
   input  logic clk,
   input  logic resetn,
   cxapbasyncbridge_cdc_launch_gry_ptr_if.slave bus
);
   logic [NUM_CH-1:0][WIDTH-1:0] out_a, bin_a;
   logic [NUM_CH-1:0]            err_a;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         cxapbasyncbridge_cdc_launch_gry_ptr_ch #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
         ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .enable_i    (bus.enable),
            .inc_i       (bus.inc[c]),
            .in_cdc_i    (bus.in_cdc[c*WIDTH +: WIDTH]),
            .err_clr_i   (bus.err_clr),
            .out_async_o (out_a[c]),
            .bin_ptr_o   (bin_a[c]),
            .gray_err_o  (err_a[c])
         );
      end
   endgenerate

   assign bus.out_async = out_a;
   assign bus.bin_ptr   = bin_a;
   assign bus.gray_err  = err_a;
endmodule

// File: tb/tb_cxapbasyncbridge_cdc_launch_gry_ptr.sv
// Bench: counter-mode and pass-through-mode instances checked against a gray-table model.
module tb_cxapbasyncbridge_cdc_launch_gry_ptr;
   localparam int W = 4;
   localparam int N = 2;

   logic clk, resetn;
   int   nchk, nerr;

   cxapbasyncbridge_cdc_launch_gry_ptr_if #(.WIDTH(W), .NUM_CH(N)) if0 ();
   cxapbasyncbridge_cdc_launch_gry_ptr_if #(.WIDTH(W), .NUM_CH(N)) if1 ();

   cxapbasyncbridge_cdc_launch_gry_ptr #(.WIDTH(W), .NUM_CH(N), .MODE(0)) dut0 (
      .clk(clk), .resetn(resetn), .bus(if0));
   cxapbasyncbridge_cdc_launch_gry_ptr #(.WIDTH(W), .NUM_CH(N), .MODE(1)) dut1 (
      .clk(clk), .resetn(resetn), .bus(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reflected gray sequence, indexed by binary count.
   int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

   int cnt [N];
   int g1  [N];
   bit e0  [N];
   bit e1  [N];

   typedef struct {
      bit         en;
      logic [7:0] in;
      bit         clr;
      logic [7:0] eo;
      logic [7:0] eb;
      logic [1:0] ee;
   } vec_t;
   vec_t tv [7];

   function automatic int bin_of(int g);
      for (int i = 0; i < 16; i++) if (gtab[i] == g) return i;
      return -1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         cnt[c] = 0; g1[c] = 0; e0[c] = 0; e1[c] = 0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < N; c++) begin
         int nc, ng;
         if (if0.err_clr) e0[c] = 0;
         if (if0.enable && if0.inc[c]) begin
            nc = (cnt[c] + 1) % 16;
            if ($countones(gtab[nc] ^ gtab[cnt[c]]) > 1) e0[c] = 1;
            cnt[c] = nc;
         end
         if (if1.err_clr) e1[c] = 0;
         if (if1.enable) begin
            ng = int'(if1.in_cdc[c*W +: W]);
            if ($countones(ng ^ g1[c]) > 1) e1[c] = 1;
            g1[c] = ng;
         end
      end
   endtask

   task automatic check_all(string tag);
      logic [7:0] o0, b0, o1, b1;
      logic [1:0] r0, r1;
      for (int c = 0; c < N; c++) begin
         o0[c*W +: W] = 4'(gtab[cnt[c]]);
         b0[c*W +: W] = 4'(cnt[c]);
         o1[c*W +: W] = 4'(g1[c]);
         b1[c*W +: W] = 4'(bin_of(g1[c]));
         r0[c] = e0[c];
         r1[c] = e1[c];
      end
      chk({tag, " m0 out_async"}, 32'(if0.out_async), 32'(o0));
      chk({tag, " m0 bin_ptr"},   32'(if0.bin_ptr),   32'(b0));
      chk({tag, " m0 gray_err"},  32'(if0.gray_err),  32'(r0));
      chk({tag, " m1 out_async"}, 32'(if1.out_async), 32'(o1));
      chk({tag, " m1 bin_ptr"},   32'(if1.bin_ptr),   32'(b1));
      chk({tag, " m1 gray_err"},  32'(if1.gray_err),  32'(r1));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      nchk = 0; nerr = 0;
      tv[0] = '{1'b1, 8'h01, 1'b0, 8'h01, 8'h01, 2'b00};
      tv[1] = '{1'b1, 8'h03, 1'b0, 8'h03, 8'h02, 2'b00};
      tv[2] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 2'b01};
      tv[3] = '{1'b1, 8'h05, 1'b1, 8'h05, 8'h06, 2'b01};
      tv[4] = '{1'b1, 8'h04, 1'b1, 8'h04, 8'h07, 2'b00};
      tv[5] = '{1'b0, 8'h0F, 1'b0, 8'h04, 8'h07, 2'b00};
      tv[6] = '{1'b1, 8'h34, 1'b0, 8'h34, 8'h27, 2'b10};

      resetn = 1'b0;
      if0.enable = 1'b0; if0.inc = '0; if0.in_cdc = '0; if0.err_clr = 1'b0;
      if1.enable = 1'b0; if1.inc = '0; if1.in_cdc = '0; if1.err_clr = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      resetn = 1'b1;

      // Idle with enable high and no increments.
      if0.enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_all("idle");
      end

      // Full wrap of channel 0.
      if0.inc = 2'b01;
      for (int i = 0; i < 16; i++) begin
         step();
         check_all("wrap");
      end
      chk("wrap bin back to 0", 32'(if0.bin_ptr[3:0]), 32'd0);

      // Channel 1 only, enable toggling.
      if0.inc = 2'b10;
      for (int i = 0; i < 8; i++) begin
         if0.enable = (i % 2 == 0);
         step();
         check_all("toggle");
      end
      chk("toggle ch1 advanced 4", 32'(if0.bin_ptr[7:4]), 32'd4);
      chk("toggle ch0 held",       32'(if0.bin_ptr[3:0]), 32'd0);
      if0.enable = 1'b0; if0.inc = '0;

      // Pass-through vectors with checker and clear priority.
      foreach (tv[i]) begin
         if1.enable = tv[i].en; if1.in_cdc = tv[i].in; if1.err_clr = tv[i].clr;
         step();
         chk($sformatf("vec%0d out_async", i), 32'(if1.out_async), 32'(tv[i].eo));
         chk($sformatf("vec%0d bin_ptr", i),   32'(if1.bin_ptr),   32'(tv[i].eb));
         chk($sformatf("vec%0d gray_err", i),  32'(if1.gray_err),  32'(tv[i].ee));
      end
      if1.enable = 1'b0; if1.err_clr = 1'b0;

      // Asynchronous reset in the middle of a cycle.
      if0.enable = 1'b1; if0.inc = 2'b01;
      for (int i = 0; i < 5; i++) step();
      chk("pre-reset bin ch0", 32'(if0.bin_ptr[3:0]), 32'd5);
      if0.inc = '0;
      @(negedge clk);
      #2 resetn = 1'b0;
      model_reset();
      #1;
      check_all("midreset");
      @(negedge clk);
      resetn = 1'b1;
      if0.inc = 2'b01;
      step();
      chk("first inc after reset", 32'(if0.out_async), 32'h01);
      check_all("post-reset");

      // Randomized run of both modes against the model.
      for (int i = 0; i < 600; i++) begin
         if0.enable  = ($urandom_range(0, 3) != 0);
         if0.inc     = 2'($urandom_range(0, 3));
         if0.err_clr = ($urandom_range(0, 7) == 0);
         if1.enable  = ($urandom_range(0, 3) != 0);
         if1.err_clr = ($urandom_range(0, 7) == 0);
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 2) != 0)
               if1.in_cdc[c*W +: W] = 4'(g1[c] ^ (1 << $urandom_range(0, 3)));
            else
               if1.in_cdc[c*W +: W] = 4'($urandom_range(0, 15));
         end
         step();
         check_all("rand");
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
